// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment codes, stabilizer state type and the
// reverse (segments to nibble) decode helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } stab_state_e;

    // Returns {err, nibble}; unknown patterns give nibble 0 with err set.
    function automatic logic [4:0] seg7_to_nibble(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            SEG_0:   r = 5'h00;
            SEG_1:   r = 5'h01;
            SEG_2:   r = 5'h02;
            SEG_3:   r = 5'h03;
            SEG_4:   r = 5'h04;
            SEG_5:   r = 5'h05;
            SEG_6:   r = 5'h06;
            SEG_7:   r = 5'h07;
            SEG_8:   r = 5'h08;
            SEG_9:   r = 5'h09;
            SEG_A:   r = 5'h0A;
            SEG_B:   r = 5'h0B;
            SEG_C:   r = 5'h0C;
            SEG_D:   r = 5'h0D;
            SEG_E:   r = 5'h0E;
            SEG_F:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_stabilizer.sv
// seg7_digit_stabilizer: registers the display lines, counts identical
// samples and strobes a capture once a digit has been stable long enough.
module seg7_digit_stabilizer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [6:0]            i_seg_n,
    input  logic [NUM_DIGITS-1:0] i_dig_sel,
    output logic                  o_cap,
    output logic [NUM_DIGITS-1:0] o_cap_sel,
    output logic [3:0]            o_nibble,
    output logic                  o_err
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;
    logic [6:0]            r_pseg;
    logic [NUM_DIGITS-1:0] r_pdig;
    stab_state_e           r_state;
    logic [CNT_W-1:0]      r_cnt;

    stab_state_e           w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_onehot;
    logic                  w_same;

    assign w_onehot = $onehot(r_dig);
    assign w_same   = (r_seg == r_pseg) && (r_dig == r_pdig);

    // Sample the raw lines once, and keep the previous sample for comparison
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg  <= '0;
            r_dig  <= '0;
            r_pseg <= '0;
            r_pdig <= '0;
        end else begin
            r_seg  <= i_seg_n;
            r_dig  <= i_dig_sel;
            r_pseg <= r_seg;
            r_pdig <= r_dig;
        end
    end

    // State and stability counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and count from the current registered sample
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_onehot) begin
                    w_cnt_nxt   = C_ONE;
                    w_state_nxt = (C_ONE >= C_STABLE) ? ST_HOLD
                                                      : ST_TRACK;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ST_TRACK: begin
                if (!w_onehot) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_same ? (r_cnt + C_ONE) : C_ONE;
                    w_state_nxt = (w_cnt_nxt >= C_STABLE) ? ST_HOLD
                                                          : ST_TRACK;
                end
            end
            ST_HOLD: begin
                // A change is not counted; tracking resumes next sample
                if (!w_same) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Capture strobe fires on the transition into HOLD
    always_comb begin
        o_cap               = (r_state != ST_HOLD) &&
                              (w_state_nxt == ST_HOLD);
        o_cap_sel           = r_dig;
        {o_err, o_nibble}   = seg7_to_nibble(r_seg);
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: assembles stabilized digits into a scan frame and
// presents it on a valid/ready output with a sticky overrun flag.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] out_value,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    input  logic                    clr_overrun
);

    logic                    w_cap;
    logic [NUM_DIGITS-1:0]   w_cap_sel;
    logic [3:0]              w_nib;
    logic                    w_err;
    logic [NUM_DIGITS-1:0]   w_cap_bits;
    logic                    w_full;
    logic                    w_free;

    logic [NUM_DIGITS-1:0]   r_mask;
    logic [4*NUM_DIGITS-1:0] r_slot_val;
    logic [NUM_DIGITS-1:0]   r_slot_err;
    logic [4*NUM_DIGITS-1:0] r_out_val;
    logic [NUM_DIGITS-1:0]   r_out_err;
    logic                    r_valid;
    logic                    r_overrun;

    seg7_digit_stabilizer #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stab (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_seg_n   (seg_n),
        .i_dig_sel (dig_sel),
        .o_cap     (w_cap),
        .o_cap_sel (w_cap_sel),
        .o_nibble  (w_nib),
        .o_err     (w_err)
    );

    assign w_cap_bits = w_cap ? w_cap_sel : '0;
    assign w_full     = &r_mask;
    assign w_free     = !r_valid || out_ready;

    // Capture mask: cleared when a full frame leaves, whether kept or dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
        end else if (w_full) begin
            r_mask <= w_cap_bits;
        end else begin
            r_mask <= r_mask | w_cap_bits;
        end
    end

    // Digit slots: a recapture simply overwrites the previous value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_val <= '0;
            r_slot_err <= '0;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (w_cap_bits[k]) begin
                    r_slot_val[4*k +: 4] <= w_nib;
                    r_slot_err[k]        <= w_err;
                end
            end
        end
    end

    // Output register and handshake, with back-to-back reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_val <= '0;
            r_out_err <= '0;
            r_valid   <= 1'b0;
        end else if (w_full && w_free) begin
            r_out_val <= r_slot_val;
            r_out_err <= r_slot_err;
            r_valid   <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_full && !w_free) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign out_value = r_out_val;
    assign out_err   = r_out_err;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed frame table, multi-cycle corner cases
// and a run-length reference model driven by random scan streams.
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_sel = 4'h0;
    logic [15:0] out_value;
    logic [3:0]  out_err;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        overrun;
    logic        clr_overrun = 1'b0;

    int n_vec = 0;
    int n_mis = 0;

    logic [6:0]  tbl [16];
    logic [19:0] got_q [$];
    logic [19:0] exp_q [$];
    logic [10:0] smp_q [$];

    typedef struct packed {
        logic [27:0] segs;
        logic [15:0] val;
        logic [3:0]  err;
    } frame_vec_t;

    frame_vec_t vt [5];

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .dig_sel     (dig_sel),
        .out_value   (out_value),
        .out_err     (out_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            got_q.push_back({out_value, out_err});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] d, input logic [6:0] s,
                        input int n);
        for (int c = 0; c < n; c++) begin
            dig_sel = d;
            seg_n   = s;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan4(input logic [27:0] segs, input int hold);
        for (int k = 0; k < 4; k++)
            step(4'(1 << k), segs[7*k +: 7], hold);
    endtask

    task automatic wait_frame(input string nm, input int base,
                              input logic [15:0] ev, input logic [3:0] ee);
        for (int c = 0; c < 20 && got_q.size() == base; c++)
            step(4'h0, 7'h7F, 1);
        step(4'h0, 7'h7F, 3);
        chk({nm, "_count"}, 32'(got_q.size()), 32'(base + 1));
        if (got_q.size() > base) begin
            chk({nm, "_value"}, 32'(got_q[base][19:4]), 32'(ev));
            chk({nm, "_err"}, 32'(got_q[base][3:0]), 32'(ee));
        end
    endtask

    function automatic logic [4:0] ref_dec(input logic [6:0] s);
        for (int v = 0; v < 16; v++)
            if (tbl[v] == s) return {1'b0, 4'(v)};
        return 5'h10;
    endfunction

    // Run-length view: a run of L identical one-hot samples is captured
    // when L, less one sample lost after a captured predecessor, reaches SC.
    task automatic build_expect();
        logic [3:0]  mask = 4'h0;
        logic [15:0] mv = 16'h0;
        logic [3:0]  me = 4'h0;
        logic        prev_cap = 1'b0;
        int          i = 0;
        while (i < smp_q.size()) begin
            int j = i;
            int len;
            logic [3:0] d;
            logic [4:0] dec;
            while (j < smp_q.size() && smp_q[j] == smp_q[i]) j++;
            len = j - i;
            d = smp_q[i][10:7];
            if ($onehot(d) && (len - (prev_cap ? 1 : 0)) >= SC) begin
                dec = ref_dec(smp_q[i][6:0]);
                for (int k = 0; k < 4; k++) begin
                    if (d[k]) begin
                        mv[4*k +: 4] = dec[3:0];
                        me[k] = dec[4];
                    end
                end
                mask = mask | d;
                if (mask == 4'hF) begin
                    exp_q.push_back({mv, me});
                    mask = 4'h0;
                end
                prev_cap = 1'b1;
            end else begin
                prev_cap = 1'b0;
            end
            i = j;
        end
    endtask

    initial begin
        int base;
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        vt[0] = '{segs: {7'b0100000, 7'b0100100, 7'b1001100, 7'b0000110},
                  val: 16'h6543, err: 4'b0000};
        vt[1] = '{segs: {7'b0111000, 7'b0001000, 7'b1111111, 7'b1001111},
                  val: 16'hFA01, err: 4'b0010};
        vt[2] = '{segs: {7'b0110001, 7'b1100000, 7'b0000100, 7'b0000000},
                  val: 16'hCB98, err: 4'b0000};
        vt[3] = '{segs: {7'b0001111, 7'b0000001, 7'b0110000, 7'b1000010},
                  val: 16'h70ED, err: 4'b0000};
        vt[4] = '{segs: {7'b1111110, 7'b1001111, 7'b0000001, 7'b0010010},
                  val: 16'h0102, err: 4'b1000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_value", 32'(out_value), 32'h0);
        chk("reset_err", 32'(out_err), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        step(4'h0, 7'h7F, 2);

        // Directed frame table
        for (int k = 0; k < 5; k++) begin
            base = got_q.size();
            scan4(vt[k].segs, 6);
            wait_frame($sformatf("table%0d", k), base, vt[k].val, vt[k].err);
        end

        // Short hold on digit 2, then rescan
        base = got_q.size();
        step(4'h1, 7'b1001111, 6);
        step(4'h2, 7'b0010010, 6);
        step(4'h4, 7'b0000110, 3);
        step(4'h8, 7'b1001100, 6);
        step(4'h0, 7'h7F, 4);
        chk("short_hold_noframe", 32'(got_q.size()), 32'(base));
        step(4'h4, 7'b0000110, 5);
        wait_frame("short_hold", base, 16'h4321, 4'h0);

        // Multi-hot select never captures; zero gaps are harmless
        base = got_q.size();
        step(4'h2, 7'b1001111, 6);
        step(4'h0, 7'h7F, 2);
        step(4'h4, 7'b0010010, 6);
        step(4'h0, 7'h7F, 2);
        step(4'h8, 7'b0000110, 6);
        step(4'h0, 7'h7F, 2);
        step(4'h3, 7'b0000000, 10);
        step(4'h0, 7'h7F, 5);
        chk("multihot_noframe", 32'(got_q.size()), 32'(base));
        step(4'h1, 7'b0000100, 6);
        wait_frame("gap_frame", base, 16'h3219, 4'h0);

        // Backpressure: second frame dropped, first held
        out_ready = 1'b0;
        base = got_q.size();
        scan4(vt[0].segs, 6);
        step(4'h0, 7'h7F, 4);
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_value1", 32'(out_value), 32'h6543);
        chk("bp_overrun0", 32'(overrun), 32'h0);
        scan4(vt[2].segs, 6);
        step(4'h0, 7'h7F, 4);
        chk("bp_overrun1", 32'(overrun), 32'h1);
        chk("bp_hold_value", 32'(out_value), 32'h6543);
        chk("bp_hold_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        step(4'h0, 7'h7F, 1);
        chk("bp_drain_valid", 32'(out_valid), 32'h0);
        chk("bp_drain_count", 32'(got_q.size()), 32'(base + 1));
        if (got_q.size() > base)
            chk("bp_drain_value", 32'(got_q[base][19:4]), 32'h6543);
        chk("bp_sticky", 32'(overrun), 32'h1);
        clr_overrun = 1'b1;
        step(4'h0, 7'h7F, 1);
        clr_overrun = 1'b0;
        chk("bp_clear", 32'(overrun), 32'h0);

        // Reset mid-frame with a pending output
        out_ready = 1'b0;
        base = got_q.size();
        scan4(vt[0].segs, 6);
        step(4'h0, 7'h7F, 4);
        chk("rst_pending_valid", 32'(out_valid), 32'h1);
        step(4'h1, vt[2].segs[6:0], 6);
        step(4'h2, vt[2].segs[13:7], 6);
        step(4'h4, vt[2].segs[20:14], 6);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_value", 32'(out_value), 32'h0);
        chk("rst_mid_err", 32'(out_err), 32'h0);
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        chk("rst_mid_overrun", 32'(overrun), 32'h0);
        step(4'h0, 7'h7F, 2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(4'h8, vt[2].segs[27:21], 6);
        step(4'h0, 7'h7F, 6);
        chk("rst_partial_noframe", 32'(got_q.size()), 32'(base));
        scan4(vt[2].segs, 6);
        wait_frame("rst_rescan", base, 16'hCB98, 4'h0);

        // Random scan streams against the run-length model
        rst_n = 1'b0;
        step(4'h0, 7'h7F, 2);
        rst_n = 1'b1;
        got_q.delete();
        for (int r = 0; r < 250; r++) begin
            int kind = $urandom_range(0, 99);
            int len = $urandom_range(1, 7);
            logic [3:0] d;
            logic [6:0] s;
            s = 7'($urandom);
            if (kind < 70) begin
                d = 4'(1 << $urandom_range(0, 3));
                if ($urandom_range(0, 4) != 0)
                    s = tbl[$urandom_range(0, 15)];
            end else if (kind < 85) begin
                d = 4'h0;
            end else begin
                d = 4'($urandom);
                if ($countones(d) < 2) d = 4'hF;
            end
            for (int c = 0; c < len; c++) smp_q.push_back({d, s});
        end
        for (int c = 0; c < 12; c++) smp_q.push_back({4'h0, 7'h7F});
        build_expect();
        foreach (smp_q[i]) step(smp_q[i][10:7], smp_q[i][6:0], 1);
        chk("rnd_frames", 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk($sformatf("rnd_frame%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
        chk("rnd_overrun", 32'(overrun), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
